i3c_phy_io_stage: RTL

- Parametrised I/O stage between the I3C/I2C controller core and the pad layer.
- Generalises the single SCL/SDA pair to NumLines lines.
- Each line has a per-line output mode: open-drain or push-pull.
- Each line has a synchroniser, a programmable glitch filter, registered edge detection and sticky bus-interference detection.
- Sits directly below the controller FSM; the controller consumes only the filtered and edge outputs.

---
 rtl/i3c_phy_io_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/i3c_phy_io_stage.sv
// Pad I/O stage for an I3C/I2C controller: per-line open-drain/push-pull drive, synchroniser,
// glitch filter, edge pulses and sticky bus-interference detection. Internal loopback: I3C_PHY_LOOPBACK_EN.
module i3c_phy_io_stage #(
   parameter int NumLines    = 2,
   parameter int SyncStages  = 2,
   parameter int FilterWidth = 4,
   parameter int SettleWidth = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumLines-1:0]    line_i,
`ifdef I3C_PHY_LOOPBACK_EN
   input  logic                   loopback_i,
`endif
   input  logic [NumLines-1:0]    ctrl_drive_i,
   input  logic [NumLines-1:0]    ctrl_val_i,
   input  logic [NumLines-1:0]    ctrl_pp_i,
   input  logic [FilterWidth-1:0] filter_cnt_i,
   input  logic [SettleWidth-1:0] settle_cnt_i,
   input  logic [NumLines-1:0]    interference_clr_i,
   output logic [NumLines-1:0]    line_o,
   output logic [NumLines-1:0]    line_en_o,
   output logic [NumLines-1:0]    line_filt_o,
   output logic [NumLines-1:0]    line_rise_o,
   output logic [NumLines-1:0]    line_fall_o,
   output logic [NumLines-1:0]    interference_o
);

   localparam logic [NumLines-1:0] AllOnes = {NumLines{1'b1}};

   logic [NumLines-1:0]    sync_r [SyncStages];
   logic [FilterWidth-1:0] filt_cnt_r [NumLines];
   logic [SettleWidth-1:0] settle_r [NumLines];
   logic [NumLines-1:0]    sync_in_s;
   logic [NumLines-1:0]    samp_s;
   logic [NumLines-1:0]    out_nxt_s;
   logic [NumLines-1:0]    en_nxt_s;
   logic [NumLines-1:0]    line_o_r;
   logic [NumLines-1:0]    line_en_r;
   logic [NumLines-1:0]    filt_r;
   logic [NumLines-1:0]    rise_r;
   logic [NumLines-1:0]    fall_r;
   logic [NumLines-1:0]    intf_r;

   // Loopback resolves the driven value against the pull-up: released lines read high.
`ifdef I3C_PHY_LOOPBACK_EN
   assign sync_in_s = loopback_i ? (~line_en_r | line_o_r) : line_i;
`else
   assign sync_in_s = line_i;
`endif
   assign samp_s = sync_r[SyncStages-1];

   // Next pad drive per line from the requested mode.
   always_comb begin
      out_nxt_s = AllOnes;
      en_nxt_s  = {NumLines{1'b0}};
      for (int i = 0; i < NumLines; i++) begin
         case ({ctrl_drive_i[i], ctrl_pp_i[i]})
            2'b11: begin
               out_nxt_s[i] = ctrl_val_i[i];
               en_nxt_s[i]  = 1'b1;
            end
            2'b10: begin
               out_nxt_s[i] = ctrl_val_i[i];
               en_nxt_s[i]  = ~ctrl_val_i[i];
            end
            default: begin
               out_nxt_s[i] = 1'b1;
               en_nxt_s[i]  = 1'b0;
            end
         endcase
      end
   end

   // Registered pad outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         line_o_r  <= AllOnes;
         line_en_r <= {NumLines{1'b0}};
      end else begin
         line_o_r  <= out_nxt_s;
         line_en_r <= en_nxt_s;
      end
   end

   // Synchroniser chain, idle-high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < SyncStages; k++) sync_r[k] <= AllOnes;
      end else begin
         sync_r[0] <= sync_in_s;
         for (int k = 1; k < SyncStages; k++) sync_r[k] <= sync_r[k-1];
      end
   end

   // Glitch filter with edge pulses issued on the same edge as the filtered update.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         filt_r <= AllOnes;
         rise_r <= {NumLines{1'b0}};
         fall_r <= {NumLines{1'b0}};
         for (int i = 0; i < NumLines; i++) filt_cnt_r[i] <= {FilterWidth{1'b0}};
      end else begin
         for (int i = 0; i < NumLines; i++) begin
            rise_r[i] <= 1'b0;
            fall_r[i] <= 1'b0;
            if (samp_s[i] == filt_r[i]) begin
               filt_cnt_r[i] <= {FilterWidth{1'b0}};
            end else if (filt_cnt_r[i] >= filter_cnt_i) begin
               filt_r[i]     <= samp_s[i];
               rise_r[i]     <= samp_s[i];
               fall_r[i]     <= ~samp_s[i];
               filt_cnt_r[i] <= {FilterWidth{1'b0}};
            end else begin
               filt_cnt_r[i] <= filt_cnt_r[i] + FilterWidth'(1);
            end
         end
      end
   end

   // Settle timing since the last drive change, then sticky mismatch flag (set beats clear).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         intf_r <= {NumLines{1'b0}};
         for (int i = 0; i < NumLines; i++) settle_r[i] <= {SettleWidth{1'b0}};
      end else begin
         for (int i = 0; i < NumLines; i++) begin
            if (!en_nxt_s[i] || (out_nxt_s[i] != line_o_r[i]) || (en_nxt_s[i] != line_en_r[i])) begin
               settle_r[i] <= {SettleWidth{1'b0}};
            end else if (settle_r[i] < settle_cnt_i) begin
               settle_r[i] <= settle_r[i] + SettleWidth'(1);
            end else begin
               settle_r[i] <= settle_cnt_i;
            end
            if (line_en_r[i] && (settle_r[i] == settle_cnt_i) && (filt_r[i] != line_o_r[i])) begin
               intf_r[i] <= 1'b1;
            end else if (interference_clr_i[i]) begin
               intf_r[i] <= 1'b0;
            end else begin
               intf_r[i] <= intf_r[i];
            end
         end
      end
   end

   assign line_o         = line_o_r;
   assign line_en_o      = line_en_r;
   assign line_filt_o    = filt_r;
   assign line_rise_o    = rise_r;
   assign line_fall_o    = fall_r;
   assign interference_o = intf_r;

endmodule
